// File: rtl/reg_xfer_ctl_if.sv
// Command and register-file control bundle for reg_xfer_ctl.
// slave  : the transfer controller (accepts commands, drives register controls and bus).
// master : the environment (decode/timing unit, reg_control/reg_file).
// Signals: cmd_* handshake, hold_clk_wait stall, done/err completion, ctl_reg_* register
// selects/masks/strobes/gates, db_in/db_out/db_oe_* data-side bus.
interface reg_xfer_ctl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [2:0]  cmd_src;
    logic [2:0]  cmd_dst;
    logic [1:0]  cmd_hilo;
    logic        hold_clk_wait;
    logic        done;
    logic        err;
    logic [1:0]  ctl_reg_gp_sel;
    logic [1:0]  ctl_reg_gp_hilo;
    logic        ctl_reg_gp_we;
    logic        ctl_reg_use_sp;
    logic        ctl_reg_sel_pc;
    logic        ctl_reg_sel_wz;
    logic        ctl_reg_sel_ir;
    logic [1:0]  ctl_reg_sys_hilo;
    logic        ctl_reg_sys_we_hi;
    logic        ctl_reg_sys_we_lo;
    logic        ctl_reg_in_hi;
    logic        ctl_reg_in_lo;
    logic        ctl_reg_out_hi;
    logic        ctl_reg_out_lo;
    logic [15:0] db_in;
    logic [15:0] db_out;
    logic        db_oe_hi;
    logic        db_oe_lo;

    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_hilo, hold_clk_wait, db_in,
        output cmd_ready, done, err,
        output ctl_reg_gp_sel, ctl_reg_gp_hilo, ctl_reg_gp_we,
        output ctl_reg_use_sp, ctl_reg_sel_pc, ctl_reg_sel_wz, ctl_reg_sel_ir,
        output ctl_reg_sys_hilo, ctl_reg_sys_we_hi, ctl_reg_sys_we_lo,
        output ctl_reg_in_hi, ctl_reg_in_lo, ctl_reg_out_hi, ctl_reg_out_lo,
        output db_out, db_oe_hi, db_oe_lo
    );

    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_hilo, hold_clk_wait, db_in,
        input  cmd_ready, done, err,
        input  ctl_reg_gp_sel, ctl_reg_gp_hilo, ctl_reg_gp_we,
        input  ctl_reg_use_sp, ctl_reg_sel_pc, ctl_reg_sel_wz, ctl_reg_sel_ir,
        input  ctl_reg_sys_hilo, ctl_reg_sys_we_hi, ctl_reg_sys_we_lo,
        input  ctl_reg_in_hi, ctl_reg_in_lo, ctl_reg_out_hi, ctl_reg_out_lo,
        input  db_out, db_oe_hi, db_oe_lo
    );
endinterface

// File: rtl/reg_xfer_ctl.sv
// Register-to-register MOVE/SWAP micro-sequencer. Reads the source (and for SWAP the
// destination) through the register file into temporaries, then writes them back crosswise.
// Ports: clk, reset (synchronous, active-high), xfer (reg_xfer_ctl_if.slave bundle).
// Parameter SWAP_EN: 1 = SWAP supported, 0 = SWAP commands run as MOVE src->dst.
module reg_xfer_ctl #(
    parameter bit SWAP_EN = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    reg_xfer_ctl_if.slave xfer
);

    typedef enum logic [2:0] {StIdle, StRdS, StRdD, StWrD, StWrS, StFin} state_e;

    state_e      state_q, state_d;
    logic        op_q;
    logic [2:0]  src_q, dst_q;
    logic [1:0]  hilo_q;
    logic        err_q;
    logic [15:0] tmp_s_q, tmp_d_q;

    logic        accept;
    logic        hold;
    logic [2:0]  tgt;
    logic        active, rd, wr;
    logic [15:0] rd_base, rd_merge;

    assign hold   = xfer.hold_clk_wait;
    assign accept = (state_q == StIdle) && xfer.cmd_valid && !hold;

    // Source side is addressed in RD_S and WR_S, destination side otherwise.
    assign tgt    = (state_q == StRdS || state_q == StWrS) ? src_q : dst_q;
    assign rd     = (state_q == StRdS) || (state_q == StRdD);
    assign wr     = (state_q == StWrD) || (state_q == StWrS);
    assign active = rd || wr;

    // Only masked bytes are captured; the others keep their previous value.
    assign rd_base  = (state_q == StRdS) ? tmp_s_q : tmp_d_q;
    assign rd_merge = {hilo_q[1] ? xfer.db_in[15:8] : rd_base[15:8],
                       hilo_q[0] ? xfer.db_in[7:0]  : rd_base[7:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= 1'b0;
            src_q   <= 3'd0;
            dst_q   <= 3'd0;
            hilo_q  <= 2'b00;
            err_q   <= 1'b0;
            tmp_s_q <= 16'h0000;
            tmp_d_q <= 16'h0000;
        end else if (!hold) begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= xfer.cmd_op & SWAP_EN;
                src_q  <= xfer.cmd_src;
                dst_q  <= xfer.cmd_dst;
                hilo_q <= xfer.cmd_hilo;
                err_q  <= (xfer.cmd_hilo == 2'b00);
            end
            if (state_q == StRdS) tmp_s_q <= rd_merge;
            if (state_q == StRdD) tmp_d_q <= rd_merge;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = (xfer.cmd_hilo == 2'b00) ? StFin : StRdS;
            StRdS:  state_d = op_q ? StRdD : StWrD;
            StRdD:  state_d = StWrD;
            StWrD:  state_d = op_q ? StWrS : StFin;
            StWrS:  state_d = StFin;
            StFin:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        xfer.cmd_ready         = (state_q == StIdle);
        xfer.done              = (state_q == StFin) && !hold;
        xfer.err               = (state_q == StFin) && !hold && err_q;
        xfer.ctl_reg_gp_sel    = 2'd0;
        xfer.ctl_reg_gp_hilo   = 2'b00;
        xfer.ctl_reg_gp_we     = 1'b0;
        xfer.ctl_reg_use_sp    = 1'b0;
        xfer.ctl_reg_sel_pc    = 1'b0;
        xfer.ctl_reg_sel_wz    = 1'b0;
        xfer.ctl_reg_sel_ir    = 1'b0;
        xfer.ctl_reg_sys_hilo  = 2'b00;
        xfer.ctl_reg_sys_we_hi = 1'b0;
        xfer.ctl_reg_sys_we_lo = 1'b0;
        xfer.ctl_reg_in_hi     = 1'b0;
        xfer.ctl_reg_in_lo     = 1'b0;
        xfer.ctl_reg_out_hi    = 1'b0;
        xfer.ctl_reg_out_lo    = 1'b0;
        xfer.db_out            = 16'h0000;
        xfer.db_oe_hi          = 1'b0;
        xfer.db_oe_lo          = 1'b0;

        if (active) begin
            if (!tgt[2]) begin
                xfer.ctl_reg_gp_sel  = tgt[1:0];
                xfer.ctl_reg_gp_hilo = hilo_q;
            end else begin
                xfer.ctl_reg_sys_hilo = hilo_q;
                unique case (tgt[1:0])
                    2'd0: xfer.ctl_reg_use_sp = 1'b1;
                    2'd1: xfer.ctl_reg_sel_pc = 1'b1;
                    2'd2: xfer.ctl_reg_sel_wz = 1'b1;
                    2'd3: xfer.ctl_reg_sel_ir = 1'b1;
                    default: ;
                endcase
            end
        end

        if (rd) begin
            xfer.ctl_reg_out_hi = hilo_q[1];
            xfer.ctl_reg_out_lo = hilo_q[0];
        end

        if (wr) begin
            // WR_D carries the source value, WR_S the destination value.
            xfer.db_out   = (state_q == StWrD) ? tmp_s_q : tmp_d_q;
            xfer.db_oe_hi = hilo_q[1];
            xfer.db_oe_lo = hilo_q[0];
            // Strobes and in-gates must not fire while stalled, or a frozen write would repeat.
            if (!hold) begin
                xfer.ctl_reg_in_hi = hilo_q[1];
                xfer.ctl_reg_in_lo = hilo_q[0];
                if (!tgt[2]) begin
                    xfer.ctl_reg_gp_we = 1'b1;
                end else begin
                    xfer.ctl_reg_sys_we_hi = hilo_q[1];
                    xfer.ctl_reg_sys_we_lo = hilo_q[0];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_xfer_ctl.sv
module tb_reg_xfer_ctl;

    logic clk = 1'b0;
    logic reset;

    reg_xfer_ctl_if xfer ();

    reg_xfer_ctl #(.SWAP_EN(1'b1)) dut (
        .clk  (clk),
        .reset(reset),
        .xfer (xfer)
    );

    always #5 clk = ~clk;

    // Register file model: 0 AF, 1 BC, 2 DE, 3 HL, 4 SP, 5 PC, 6 WZ, 7 IR.
    logic [15:0] rf [8];
    logic        pre_en;
    logic [2:0]  pre_code;
    logic [15:0] pre_val;
    logic [2:0]  sel_code;
    logic        sys_sel;

    always_comb begin
        sys_sel  = xfer.ctl_reg_use_sp | xfer.ctl_reg_sel_pc | xfer.ctl_reg_sel_wz |
                   xfer.ctl_reg_sel_ir;
        sel_code = {1'b0, xfer.ctl_reg_gp_sel};
        if (xfer.ctl_reg_use_sp) sel_code = 3'd4;
        if (xfer.ctl_reg_sel_pc) sel_code = 3'd5;
        if (xfer.ctl_reg_sel_wz) sel_code = 3'd6;
        if (xfer.ctl_reg_sel_ir) sel_code = 3'd7;
        xfer.db_in = {xfer.ctl_reg_out_hi ? rf[sel_code][15:8] : 8'h00,
                      xfer.ctl_reg_out_lo ? rf[sel_code][7:0]  : 8'h00};
    end

    always @(posedge clk) begin
        if (pre_en) begin
            rf[pre_code] <= pre_val;
        end else begin
            if (xfer.ctl_reg_gp_we && !sys_sel) begin
                if (xfer.ctl_reg_gp_hilo[1] && xfer.ctl_reg_in_hi)
                    rf[sel_code][15:8] <= xfer.db_out[15:8];
                if (xfer.ctl_reg_gp_hilo[0] && xfer.ctl_reg_in_lo)
                    rf[sel_code][7:0] <= xfer.db_out[7:0];
            end
            if (sys_sel && xfer.ctl_reg_sys_we_hi && xfer.ctl_reg_in_hi)
                rf[sel_code][15:8] <= xfer.db_out[15:8];
            if (sys_sel && xfer.ctl_reg_sys_we_lo && xfer.ctl_reg_in_lo)
                rf[sel_code][7:0] <= xfer.db_out[7:0];
        end
    end

    // Every controller output except cmd_ready, and the select/strobe/gate subset.
    logic [36:0] outs_all;
    logic        sel_act;
    logic        strobes;
    assign outs_all = {xfer.done, xfer.err, xfer.ctl_reg_gp_sel, xfer.ctl_reg_gp_hilo,
                       xfer.ctl_reg_gp_we, xfer.ctl_reg_use_sp, xfer.ctl_reg_sel_pc,
                       xfer.ctl_reg_sel_wz, xfer.ctl_reg_sel_ir, xfer.ctl_reg_sys_hilo,
                       xfer.ctl_reg_sys_we_hi, xfer.ctl_reg_sys_we_lo, xfer.ctl_reg_in_hi,
                       xfer.ctl_reg_in_lo, xfer.ctl_reg_out_hi, xfer.ctl_reg_out_lo,
                       xfer.db_out, xfer.db_oe_hi, xfer.db_oe_lo};
    assign strobes  = xfer.ctl_reg_gp_we | xfer.ctl_reg_sys_we_hi | xfer.ctl_reg_sys_we_lo |
                      xfer.ctl_reg_in_hi | xfer.ctl_reg_in_lo;
    assign sel_act  = strobes | (xfer.ctl_reg_gp_hilo != 2'b00) | sys_sel |
                      (xfer.ctl_reg_sys_hilo != 2'b00) | xfer.ctl_reg_out_hi |
                      xfer.ctl_reg_out_lo | xfer.db_oe_hi | xfer.db_oe_lo;

    int n_asrt = 0;
    int n_fail = 0;

    int r_lat, r_err, r_gpwe, r_gpwe_pos, r_syswe, r_inhi, r_inlo, r_oelo, r_hold_strb, r_act;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [2:0] code, input logic [15:0] val);
        @(negedge clk);
        pre_en   = 1'b1;
        pre_code = code;
        pre_val  = val;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    // Issues one command and watches it cycle by cycle (n = cycles since the accept edge).
    task automatic run_cmd(input logic op, input logic [2:0] src, input logic [2:0] dst,
                           input logic [1:0] hilo, input int hold_at, input int hold_len);
        int hold_left;
        r_lat = -1; r_err = 0; r_gpwe = 0; r_gpwe_pos = 0; r_syswe = 0;
        r_inhi = 0; r_inlo = 0; r_oelo = 0; r_hold_strb = 0; r_act = 0;
        hold_left = 0;
        @(negedge clk);
        xfer.cmd_valid = 1'b1;
        xfer.cmd_op    = op;
        xfer.cmd_src   = src;
        xfer.cmd_dst   = dst;
        xfer.cmd_hilo  = hilo;
        @(posedge clk);
        #1 xfer.cmd_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (xfer.ctl_reg_gp_we) begin
                r_gpwe++;
                r_gpwe_pos = r_gpwe_pos | (1 << n);
            end
            if (xfer.ctl_reg_sys_we_hi || xfer.ctl_reg_sys_we_lo) r_syswe++;
            if (xfer.ctl_reg_in_hi) r_inhi++;
            if (xfer.ctl_reg_in_lo) r_inlo++;
            if (xfer.db_oe_lo) r_oelo++;
            if (xfer.hold_clk_wait && strobes) r_hold_strb++;
            if (sel_act) r_act++;
            if (xfer.done) begin
                r_lat = n;
                r_err = int'(xfer.err);
                break;
            end
            if (n == hold_at) begin
                xfer.hold_clk_wait = 1'b1;
                hold_left = hold_len;
            end else if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) xfer.hold_clk_wait = 1'b0;
            end
        end
    endtask

    initial begin
        int dcnt;
        reset              = 1'b1;
        pre_en             = 1'b0;
        pre_code           = 3'd0;
        pre_val            = 16'h0000;
        xfer.cmd_valid     = 1'b0;
        xfer.cmd_op        = 1'b0;
        xfer.cmd_src       = 3'd0;
        xfer.cmd_dst       = 3'd0;
        xfer.cmd_hilo      = 2'b00;
        xfer.hold_clk_wait = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(xfer.cmd_ready), 32'd1);
        chk("rst_outs_lo", outs_all[31:0], 32'd0);
        chk("rst_outs_hi", 32'(outs_all[36:32]), 32'd0);
        reset = 1'b0;

        // MOVE BC->HL, full word
        preload(3'd1, 16'h1234);
        preload(3'd3, 16'h0000);
        run_cmd(1'b0, 3'd1, 3'd3, 2'b11, 0, 0);
        chk("mv_lat", r_lat, 3);
        chk("mv_err", r_err, 0);
        chk("mv_hl", 32'(rf[3]), 32'h1234);
        chk("mv_bc", 32'(rf[1]), 32'h1234);
        chk("mv_gpwe", r_gpwe, 1);

        // SWAP DE,HL
        preload(3'd2, 16'hAAAA);
        preload(3'd3, 16'h5555);
        run_cmd(1'b1, 3'd2, 3'd3, 2'b11, 0, 0);
        chk("sw_lat", r_lat, 5);
        chk("sw_de", 32'(rf[2]), 32'h5555);
        chk("sw_hl", 32'(rf[3]), 32'hAAAA);
        chk("sw_gpwe_pos", r_gpwe_pos, 32'h18);

        // System-register moves
        preload(3'd3, 16'h8001);
        run_cmd(1'b0, 3'd3, 3'd4, 2'b11, 0, 0);
        chk("sp_lat", r_lat, 3);
        chk("sp_val", 32'(rf[4]), 32'h8001);
        chk("sp_syswe", r_syswe, 1);
        chk("sp_gpwe", r_gpwe, 0);
        preload(3'd6, 16'h0042);
        run_cmd(1'b0, 3'd6, 3'd5, 2'b11, 0, 0);
        chk("pc_val", 32'(rf[5]), 32'h0042);
        chk("pc_syswe", r_syswe, 1);
        chk("pc_gpwe", r_gpwe, 0);

        // Hi-byte move AF->BC
        preload(3'd0, 16'h77FF);
        preload(3'd1, 16'h0000);
        run_cmd(1'b0, 3'd0, 3'd1, 2'b10, 0, 0);
        chk("bt_bc", 32'(rf[1]), 32'h7700);
        chk("bt_af", 32'(rf[0]), 32'h77FF);
        chk("bt_inlo", r_inlo, 0);
        chk("bt_inhi", r_inhi, 1);
        chk("bt_oelo", r_oelo, 0);

        // SWAP with a 3-cycle stall in RD_D
        preload(3'd2, 16'h1111);
        preload(3'd3, 16'h2222);
        run_cmd(1'b1, 3'd2, 3'd3, 2'b11, 2, 3);
        chk("hd_lat", r_lat, 8);
        chk("hd_strb", r_hold_strb, 0);
        chk("hd_de", 32'(rf[2]), 32'h2222);
        chk("hd_hl", 32'(rf[3]), 32'h1111);
        chk("hd_gpwe", r_gpwe, 2);

        // Illegal mask
        run_cmd(1'b0, 3'd1, 3'd2, 2'b00, 0, 0);
        chk("il_lat", r_lat, 1);
        chk("il_err", r_err, 1);
        chk("il_act", r_act, 0);
        chk("il_de", 32'(rf[2]), 32'h2222);

        // Reset during WR_D of a SWAP
        @(negedge clk);
        xfer.cmd_valid = 1'b1;
        xfer.cmd_op    = 1'b1;
        xfer.cmd_src   = 3'd2;
        xfer.cmd_dst   = 3'd3;
        xfer.cmd_hilo  = 2'b11;
        @(posedge clk);
        #1 xfer.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("ra_wrd_we", 32'(xfer.ctl_reg_gp_we), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("ra_ready", 32'(xfer.cmd_ready), 32'd1);
        chk("ra_outs_lo", outs_all[31:0], 32'd0);
        chk("ra_outs_hi", 32'(outs_all[36:32]), 32'd0);
        reset = 1'b0;
        dcnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (xfer.done || strobes) dcnt++;
        end
        chk("ra_nodone", dcnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
